// File: rtl/ex_muldiv.sv
//==============================================================================
// Module      : ex_muldiv
// Description : EX-stage HI/LO unit. Iterative MULT/MULTU/DIV/DIVU plus
//               MTHI/MTLO. Define MULDIV_FAST_MUL_EN for a single-cycle multiply.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        iValid,
    input  logic [5:0]  iFun,
    input  logic [31:0] iRegOut1,
    input  logic [31:0] iRegOut2,
    output logic        oStall,
    output logic [31:0] oHi,
    output logic [31:0] oLo,
    output logic        oDone
);

    localparam logic [5:0] c_FUN_MTHI  = 6'h11;
    localparam logic [5:0] c_FUN_MTLO  = 6'h13;
    localparam logic [5:0] c_FUN_MULT  = 6'h18;
    localparam logic [5:0] c_FUN_MULTU = 6'h19;
    localparam logic [5:0] c_FUN_DIV   = 6'h1A;
    localparam logic [5:0] c_FUN_DIVU  = 6'h1B;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    logic [1:0]  r_state, w_nextState;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opB;
    logic        r_negQ, r_negR, r_isDiv, r_divZero;
    logic [31:0] r_hi, r_lo;

    logic        w_isMul, w_isDiv, w_signed, w_signA, w_signB;
    logic [31:0] w_magA, w_magB;
    logic        w_accept;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;
    logic [32:0] w_divTop;
    logic        w_divGe;
    logic [31:0] w_divSub;
    logic [63:0] w_divNext;

    assign w_isMul  = (iFun == c_FUN_MULT) || (iFun == c_FUN_MULTU);
    assign w_isDiv  = (iFun == c_FUN_DIV)  || (iFun == c_FUN_DIVU);
    assign w_signed = (iFun == c_FUN_MULT) || (iFun == c_FUN_DIV);
    assign w_signA  = w_signed & iRegOut1[31];
    assign w_signB  = w_signed & iRegOut2[31];
    assign w_magA   = w_signA ? -iRegOut1 : iRegOut1;
    assign w_magB   = w_signB ? -iRegOut2 : iRegOut2;

`ifdef MULDIV_FAST_MUL_EN
    logic        w_fastMul;
    logic [63:0] w_fastProd;
    assign w_accept   = (r_state == c_ST_IDLE) && iValid && w_isDiv && !rst;
    assign w_fastMul  = (r_state == c_ST_IDLE) && iValid && w_isMul && !rst;
    assign w_fastProd = {{32{w_signA}}, iRegOut1} * {{32{w_signB}}, iRegOut2};
`else
    logic [32:0] w_mulSum;
    logic [63:0] w_mulNext;
    assign w_accept  = (r_state == c_ST_IDLE) && iValid && (w_isMul || w_isDiv) && !rst;
    // Shift-add: add multiplicand into the upper half, then shift right one bit.
    assign w_mulSum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opB : 32'd0)};
    assign w_mulNext = {w_mulSum, r_acc[31:1]};
`endif

    // Restoring step: the shifted partial remainder needs 33 bits before the trial subtract.
    assign w_divTop  = r_acc[63:31];
    assign w_divGe   = (w_divTop >= {1'b0, r_opB});
    assign w_divSub  = w_divTop[31:0] - r_opB;
    assign w_divNext = w_divGe ? {w_divSub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

    // Divide by zero keeps the all-ones quotient unsigned; remainder restores the dividend.
    assign w_prod = r_negQ ? -r_acc : r_acc;
    assign w_quot = (r_negQ && !r_divZero) ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem  = r_negR ? -r_acc[63:32] : r_acc[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_isMul ? c_ST_MUL : c_ST_DIV;
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (r_cnt == 6'd31) begin
                    w_nextState = c_ST_FIX;
                end
            end
            c_ST_FIX: w_nextState = c_ST_IDLE;
            default:  w_nextState = c_ST_IDLE;
        endcase
    end

    always_comb begin
        oStall = 1'b0;
        oDone  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                oStall = w_accept;
`ifdef MULDIV_FAST_MUL_EN
                oDone  = w_fastMul;
`endif
            end
            c_ST_MUL, c_ST_DIV: oStall = iValid;
            c_ST_FIX:           oDone  = !rst;
            default: begin
                oStall = 1'b0;
                oDone  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 6'd0;
            r_acc     <= 64'd0;
            r_opB     <= 32'd0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_acc     <= {32'd0, w_magA};
                        r_opB     <= w_magB;
                        r_negQ    <= w_signA ^ w_signB;
                        r_negR    <= w_signA;
                        r_isDiv   <= w_isDiv;
                        r_divZero <= (iRegOut2 == 32'd0);
                        r_cnt     <= 6'd0;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (w_fastMul) begin
                        r_hi <= w_fastProd[63:32];
                        r_lo <= w_fastProd[31:0];
`endif
                    end else if (iValid && (iFun == c_FUN_MTHI)) begin
                        r_hi <= iRegOut1;
                    end else if (iValid && (iFun == c_FUN_MTLO)) begin
                        r_lo <= iRegOut1;
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                c_ST_MUL: begin
                    r_acc <= w_mulNext;
                    r_cnt <= r_cnt + 6'd1;
                end
`endif
                c_ST_DIV: begin
                    r_acc <= w_divNext;
                    r_cnt <= r_cnt + 6'd1;
                end
                c_ST_FIX: begin
                    if (r_isDiv) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign oHi = r_hi;
    assign oLo = r_lo;

endmodule

`default_nettype wire
